// File: rtl/nbcac_decoder_10_rx_pkg.sv
// Shared types and helpers for the 10-wire NBCAC receive path.
package nbcac_pkg;

  localparam int unsigned NBCAC_N_WIRES = 10;
  localparam int unsigned NBCAC_N_DATA  = 7;

  typedef logic [NBCAC_N_WIRES:1]  nbcac_word_t;
  typedef logic [NBCAC_N_DATA-1:0] nbcac_data_t;

  // True when any adjacent wire pair toggles in opposite directions between prev and cur.
  function automatic logic nbcac_xtalk_viol(nbcac_word_t prev, nbcac_word_t cur);
    nbcac_word_t t;
    logic        viol;
    t    = prev ^ cur;
    viol = 1'b0;
    for (int unsigned i = 1; i < NBCAC_N_WIRES; i++) begin
      viol = viol | (t[i] & t[i+1] & (cur[i] ^ cur[i+1]));
    end
    return viol;
  endfunction

endpackage

// File: rtl/nbcac_decoder_10_rx_if.sv
// Codeword-in / decoded-data-out bus of the NBCAC receive stage.
interface nbcac_decoder_10_rx_if;
  import nbcac_pkg::*;

  nbcac_word_t codein;
  logic        codein_valid;
  nbcac_data_t dataout;
  logic        dataout_valid;
  logic        code_err;
  logic        xtalk_err;

  modport master (
    output codein, codein_valid,
    input  dataout, dataout_valid, code_err, xtalk_err
  );

  modport slave (
    input  codein, codein_valid,
    output dataout, dataout_valid, code_err, xtalk_err
  );
endinterface

// File: rtl/nbcac_decoder_10_rx_dec.sv
// 10-wire NBCAC to 7-bit decoder; duplicated pairs are ANDed, exact inverse on legal words.
module nbcac_7di_decoder_core
  import nbcac_pkg::*;
(
  input  nbcac_word_t d,
  output nbcac_data_t v
);
  always_comb begin
    v = {d[10] & d[9], d[8], d[7] & d[6], d[5], d[4] & d[3], d[2], d[1]};
  end
endmodule

// File: rtl/nbcac_decoder_10_rx_enc.sv
// 7-bit to 10-wire NBCAC encoder: d6, d4 and d2 each drive an adjacent wire pair.
module nbcac_7di_encoder_core
  import nbcac_pkg::*;
(
  input  nbcac_data_t d,
  output nbcac_word_t v
);
  always_comb begin
    v = {d[6], d[6], d[5], d[4], d[4], d[3], d[2], d[2], d[1], d[0]};
  end
endmodule

// File: rtl/nbcac_decoder_10_rx.sv
// NBCAC receive stage: capture, decode, legality and crosstalk checks, saturating error counters.
module nbcac_decoder_10_rx
  import nbcac_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic                 clock,
  input  logic                 rst_n,
  nbcac_decoder_10_rx_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     code_err_cnt,
  output logic [CNT_W-1:0]     xtalk_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  nbcac_word_t s1_word;
  logic        s1_vld;
  nbcac_word_t prev_word;
  logic        prev_vld;
  nbcac_data_t dec_data;
  nbcac_word_t re_enc;
  logic        code_err_nxt;
  logic        xtalk_err_nxt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_word <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= bus.codein_valid;
      if (bus.codein_valid) begin
        s1_word <= bus.codein;
      end
    end
  end

  nbcac_7di_decoder_core u_dec (
    .d (s1_word),
    .v (dec_data)
  );

  // A word is legal exactly when re-encoding its decode reproduces it.
  nbcac_7di_encoder_core u_enc (
    .d (dec_data),
    .v (re_enc)
  );

  always_comb begin
    code_err_nxt  = (re_enc != s1_word);
    xtalk_err_nxt = prev_vld & nbcac_xtalk_viol(prev_word, s1_word);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.dataout       <= '0;
      bus.dataout_valid <= 1'b0;
      bus.code_err      <= 1'b0;
      bus.xtalk_err     <= 1'b0;
      prev_word         <= '0;
      prev_vld          <= 1'b0;
    end else begin
      bus.dataout_valid <= s1_vld;
      if (s1_vld) begin
        bus.dataout   <= dec_data;
        bus.code_err  <= code_err_nxt;
        bus.xtalk_err <= xtalk_err_nxt;
        prev_word     <= s1_word;
        prev_vld      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code_err_cnt <= '0;
    end else if (cnt_clr) begin
      code_err_cnt <= '0;
    end else if (s1_vld && code_err_nxt && (code_err_cnt != CNT_MAX)) begin
      code_err_cnt <= code_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      xtalk_err_cnt <= '0;
    end else if (cnt_clr) begin
      xtalk_err_cnt <= '0;
    end else if (s1_vld && xtalk_err_nxt && (xtalk_err_cnt != CNT_MAX)) begin
      xtalk_err_cnt <= xtalk_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nbcac_decoder_10_rx.sv
// Scoreboard bench for nbcac_decoder_10_rx with directed vectors (CNT_W=4).
module tb_nbcac_decoder_10_rx;

  typedef struct {
    logic [6:0] d;
    logic       ce;
    logic       xe;
  } exp_t;

  // Source data bit for wires 1..10 (index 0 = wire 1).
  localparam int unsigned SRC [10] = '{0, 1, 2, 2, 3, 4, 4, 5, 6, 6};

  logic       clock;
  logic       rst_n;
  logic       cnt_clr;
  logic [3:0] code_err_cnt;
  logic [3:0] xtalk_err_cnt;

  nbcac_decoder_10_rx_if bus ();

  nbcac_decoder_10_rx #(.CNT_W(4)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .bus           (bus),
    .cnt_clr       (cnt_clr),
    .code_err_cnt  (code_err_cnt),
    .xtalk_err_cnt (xtalk_err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t q [$];
  exp_t held;
  logic [9:0] m_prev;
  logic       m_prev_vld;
  int   m_code_cnt;
  int   m_xtalk_cnt;
  logic clr_seen;
  int   run;
  int   last_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] m_enc(input logic [6:0] d);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[k] = d[SRC[k]];
    return w;
  endfunction

  function automatic logic [6:0] m_dec(input logic [9:0] w);
    return {w[8] & w[9], w[7], w[5] & w[6], w[4], w[2] & w[3], w[1], w[0]};
  endfunction

  function automatic logic m_xtalk(input logic [9:0] p, input logic [9:0] c);
    logic [9:0] t;
    logic [9:0] opp;
    t   = p ^ c;
    opp = t & (t >> 1) & (c ^ (c >> 1));
    return |opp[8:0];
  endfunction

  always @(posedge clock) clr_seen = cnt_clr;

  // Monitor: pops expectations on each valid output, checks holds and counters.
  always @(negedge clock) begin
    exp_t e;
    logic popped;
    popped = 1'b0;
    if (!rst_n) begin
      m_code_cnt  = 0;
      m_xtalk_cnt = 0;
      held.d  = '0;
      held.ce = 1'b0;
      held.xe = 1'b0;
      run = 0;
    end else begin
      if (bus.dataout_valid) begin
        run++;
        if (q.size() == 0) begin
          check("spurious_valid", 32'(q.size()), 1);
        end else begin
          e = q.pop_front();
          popped = 1'b1;
          check("dataout", 32'(bus.dataout), 32'(e.d));
          check("flags", 32'({bus.code_err, bus.xtalk_err}), 32'({e.ce, e.xe}));
          held = e;
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        check("hold", 32'({bus.dataout, bus.code_err, bus.xtalk_err}),
              32'({held.d, held.ce, held.xe}));
      end
      if (clr_seen) begin
        m_code_cnt  = 0;
        m_xtalk_cnt = 0;
      end else if (popped) begin
        if (e.ce && m_code_cnt < 15)  m_code_cnt++;
        if (e.xe && m_xtalk_cnt < 15) m_xtalk_cnt++;
      end
      if (clr_seen || bus.dataout_valid) begin
        check("code_err_cnt", 32'(code_err_cnt), m_code_cnt);
        check("xtalk_err_cnt", 32'(xtalk_err_cnt), m_xtalk_cnt);
      end
    end
  end

  task automatic send(input logic [9:0] w);
    exp_t e;
    @(posedge clock);
    #1;
    bus.codein       = w;
    bus.codein_valid = 1'b1;
    cnt_clr          = 1'b0;
    e.d  = m_dec(w);
    e.ce = (m_enc(m_dec(w)) != w);
    e.xe = m_prev_vld & m_xtalk(m_prev, w);
    m_prev     = w;
    m_prev_vld = 1'b1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      bus.codein_valid = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    check("drain_empty", 32'(q.size()), 0);
  endtask

  task automatic clr_pulse();
    @(posedge clock);
    #1;
    bus.codein_valid = 1'b0;
    cnt_clr          = 1'b1;
    @(posedge clock);
    #1;
    cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    rst_n            = 1'b0;
    bus.codein_valid = 1'b0;
    q.delete();
    m_prev     = '0;
    m_prev_vld = 1'b0;
    #1;
    check("reset_outputs", 32'({bus.dataout, bus.dataout_valid, bus.code_err,
                                bus.xtalk_err, code_err_cnt, xtalk_err_cnt}), 0);
    repeat (2) @(posedge clock);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] bad;
    logic       found;
    rst_n            = 1'b0;
    cnt_clr          = 1'b0;
    bus.codein       = '0;
    bus.codein_valid = 1'b0;
    m_prev           = '0;
    m_prev_vld       = 1'b0;
    last_run         = 0;
    #23;
    check("reset_state", 32'({bus.dataout, bus.dataout_valid, bus.code_err,
                              bus.xtalk_err, code_err_cnt, xtalk_err_cnt}), 0);
    rst_n = 1'b1;

    // Full-codebook sweep, back to back.
    for (int v = 0; v < 128; v++) send(m_enc(7'(v)));
    drain();
    check("sweep_valid_run", 32'(last_run), 128);

    // Opposite toggle on wires 1/2 vs. same-direction change.
    clr_pulse();
    send(10'b0000000001);
    send(10'b0000000010);
    drain();
    check("xtalk_cnt_after_pair", 32'(xtalk_err_cnt), 1);
    send(10'b0000000001);
    send(10'b0000000011);
    drain();

    // Illegal word discovered by exhaustive search.
    found = 1'b0;
    bad   = '0;
    for (int w = 0; w < 1024; w++) begin
      if (m_enc(m_dec(10'(w))) != 10'(w)) begin
        bad   = 10'(w);
        found = 1'b1;
        break;
      end
    end
    check("illegal_found", 32'(found), 1);
    clr_pulse();
    send(bad);
    send(m_enc(7'd0));
    drain();
    check("code_cnt_single", 32'(code_err_cnt), 1);

    // Saturation, then clear colliding with an increment.
    clr_pulse();
    repeat (20) send(bad);
    drain();
    check("code_cnt_saturated", 32'(code_err_cnt), 15);
    repeat (3) send(bad);
    @(posedge clock);
    #1;
    bus.codein_valid = 1'b0;
    cnt_clr          = 1'b1;
    @(posedge clock);
    #1;
    cnt_clr = 1'b0;
    drain();
    check("code_cnt_clr_priority", 32'(code_err_cnt), 0);

    // First word after reset, idle gap, then opposite toggle vs. enc(5).
    do_reset();
    send(m_enc(7'd5));
    idle(3);
    send(m_enc(7'd6));
    drain();
    check("gap_xtalk_cnt", 32'(xtalk_err_cnt), 1);

    // Asynchronous reset with two words in flight.
    send(m_enc(7'd1));
    send(m_enc(7'd2));
    do_reset();
    send(m_enc(7'd2));
    @(posedge clock);
    #1;
    bus.codein_valid = 1'b0;
    check("latency_edge1", 32'(bus.dataout_valid), 0);
    @(posedge clock);
    #1;
    check("latency_edge2", 32'(bus.dataout_valid), 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
